// File: rtl/rsa_host_ctrl.sv
// -----------------------------------------------------------------------------
// rsa_host_ctrl
//
// Host-side controller for the RSA pipelined CPU. It assembles an operand block
// from a little-endian byte stream and writes it word by word into data memory.
// It then raises start and waits for EndFlag, bounded by a cycle timeout.
// Finally it reads the result words back and returns them as a byte stream.
// While the CPU is idle this block owns the data-memory port (host_sel=1).
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/     host byte input (valid&ready handshake)
//   in_data
//   out_valid/out_ready/   result byte output (valid&ready handshake)
//   out_data
//   start, EndFlag         CPU start (held through RUN) / CPU completion
//   host_sel               1: this block drives the memory port, 0: CPU does
//   MemWrite, DataAdr,     data-memory write enable, byte address, write word
//   WriteData
//   ReadData               data-memory read word, one cycle after DataAdr
//   busy                   high whenever not idle
//   timeout_err            sticky RUN-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module rsa_host_ctrl #(
  parameter int unsigned IN_BASE   = 0,
  parameter int unsigned IN_WORDS  = 4,
  parameter int unsigned OUT_BASE  = 64,
  parameter int unsigned OUT_WORDS = 2,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        start,
  input  logic        EndFlag,
  output logic        host_sel,
  output logic        MemWrite,
  output logic [31:0] DataAdr,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData,
  output logic        busy,
  output logic        timeout_err
);

  // S_WRITE is the single MemWrite cycle that follows each completed input
  // word. S_CAPT is the cycle in which the synchronous memory read returns.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RUN,
    S_FETCH,
    S_CAPT,
    S_SEND
  } state_e;

  localparam logic [31:0] IN_BASE_W  = 32'(IN_BASE);
  localparam logic [31:0] OUT_BASE_W = 32'(OUT_BASE);
  localparam logic [7:0]  LAST_IN    = 8'(IN_WORDS - 1);
  localparam logic [7:0]  LAST_OUT   = 8'(OUT_WORDS - 1);
  localparam logic [15:0] LAST_RUN   = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] word_q,  word_d;   // input word being assembled
  logic [31:0] oword_q, oword_d;  // result word being sent
  logic [1:0]  bcnt_q,  bcnt_d;   // byte index within the current word
  logic [7:0]  widx_q,  widx_d;   // input word index
  logic [7:0]  ridx_q,  ridx_d;   // result word index
  logic [15:0] tcnt_q,  tcnt_d;   // RUN cycle counter
  logic        tout_q,  tout_d;   // sticky timeout flag

  logic [31:0] in_adr;
  logic [31:0] out_adr;

  // Word index scaled to a byte address; 32-bit wrap-around is intended.
  assign in_adr  = IN_BASE_W  + {22'd0, widx_q, 2'b00};
  assign out_adr = OUT_BASE_W + {22'd0, ridx_q, 2'b00};

  // Every output is decoded from registered state, so an asynchronous reset
  // forces all of them (start included) to their idle values immediately.
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    oword_d     = oword_q;
    bcnt_d      = bcnt_q;
    widx_d      = widx_q;
    ridx_d      = ridx_q;
    tcnt_d      = tcnt_q;
    tout_d      = tout_q;

    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'd0;
    start       = 1'b0;
    host_sel    = 1'b1;
    MemWrite    = 1'b0;
    DataAdr     = 32'd0;
    WriteData   = 32'd0;
    busy        = (state_q != S_IDLE);
    timeout_err = tout_q;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // First byte of a job: byte 0 of word 0.
          word_d  = {in_data, word_q[31:8]};
          bcnt_d  = 2'd1;
          widx_d  = 8'd0;
          ridx_d  = 8'd0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Shift in from the top so the first byte ends up in [7:0].
          word_d = {in_data, word_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        MemWrite  = 1'b1;
        DataAdr   = in_adr;
        WriteData = word_q;
        widx_d    = widx_q + 8'd1;
        if (widx_q == LAST_IN) begin
          tcnt_d  = 16'd0;
          state_d = S_RUN;
        end else begin
          state_d = S_LOAD;
        end
      end

      S_RUN: begin
        host_sel = 1'b0;
        start    = 1'b1;
        tcnt_d   = tcnt_q + 16'd1;
        // EndFlag has priority over a timeout landing in the same cycle.
        if (EndFlag) begin
          state_d = S_FETCH;
        end else if (tcnt_q == LAST_RUN) begin
          tout_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        DataAdr = out_adr;
        state_d = S_CAPT;
      end

      S_CAPT: begin
        // Address is held so the read word matches even if the memory
        // re-samples it; the word presented now belongs to out_adr.
        DataAdr = out_adr;
        oword_d = ReadData;
        state_d = S_SEND;
      end

      S_SEND: begin
        out_valid = 1'b1;
        out_data  = oword_q[7:0];
        if (out_ready) begin
          oword_d = {8'd0, oword_q[31:8]};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (ridx_q < LAST_OUT) begin
              ridx_d  = ridx_q + 8'd1;
              state_d = S_FETCH;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      word_q  <= 32'd0;
      oword_q <= 32'd0;
      bcnt_q  <= 2'd0;
      widx_q  <= 8'd0;
      ridx_q  <= 8'd0;
      tcnt_q  <= 16'd0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      oword_q <= oword_d;
      bcnt_q  <= bcnt_d;
      widx_q  <= widx_d;
      ridx_q  <= ridx_d;
      tcnt_q  <= tcnt_d;
      tout_q  <= tout_d;
    end
  end

endmodule

// File: tb/tb_rsa_host_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rsa_host_ctrl
//
// Self-checking bench for rsa_host_ctrl. A small data memory and CPU model sit
// around the DUT. The CPU model writes the job's result words while start is
// high and raises EndFlag after a chosen number of start cycles (0: never).
// Each job's expectations come from a job-level reference model: the memory
// writes, the start duration, the timeout flag and the output byte sequence.
// -----------------------------------------------------------------------------
module tb_rsa_host_ctrl;

  localparam int unsigned IN_BASE   = 0;
  localparam int unsigned IN_WORDS  = 4;
  localparam int unsigned OUT_BASE  = 64;
  localparam int unsigned OUT_WORDS = 2;
  localparam int unsigned TIMEOUT   = 100;
  localparam int          RES_IDX   = OUT_BASE / 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        start;
  logic        EndFlag;
  logic        host_sel;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        busy;
  logic        timeout_err;

  always #5 clk = ~clk;

  rsa_host_ctrl #(
    .IN_BASE  (IN_BASE),
    .IN_WORDS (IN_WORDS),
    .OUT_BASE (OUT_BASE),
    .OUT_WORDS(OUT_WORDS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .start      (start),
    .EndFlag    (EndFlag),
    .host_sel   (host_sel),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [3:0][31:0] in_w;
    logic [1:0][31:0] res_w;
    int               delay;      // start cycles until EndFlag, 0 = never
    int               rmode;      // out_ready: 0 always, 1 toggle, 2 random
    int               exp_start;  // expected start-high cycles
    bit               exp_to;     // expected timeout_err after the job
  } job_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Environment state driven by the test sequence.
  logic [1:0][31:0] res_w;
  int               end_delay;
  int               ready_mode;
  bit               hold_junk;
  logic [7:0]       in_q[$];

  // Observations collected by the monitor.
  logic [63:0] wr_q[$];
  logic [7:0]  out_q[$];
  int          acc_cnt;
  int          start_cnt;
  int          viol;
  bit          prev_hold;
  logic [7:0]  prev_data;

  // Reference expectations for the current job.
  logic [63:0] exp_wr[$];
  logic [7:0]  exp_bytes[$];

  // Data memory with synchronous read; the CPU writes its results while running.
  logic [31:0] mem [0:63];
  int          run_cnt;

  always @(posedge clk) begin
    if (host_sel && MemWrite) mem[DataAdr[7:2]] <= WriteData;
    if (start) begin
      mem[RES_IDX]     <= res_w[0];
      mem[RES_IDX + 1] <= res_w[1];
    end
    ReadData <= mem[DataAdr[7:2]];
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) run_cnt <= 0;
    else        run_cnt <= start ? run_cnt + 1 : 0;
  end

  assign EndFlag = start && (end_delay != 0) && (run_cnt == end_delay - 1);

  // Input/output drivers, updated just after each rising edge.
  initial begin
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      in_valid = (in_q.size() > 0) || (hold_junk && start);
      in_data  = (in_q.size() > 0) ? in_q[0] : 8'hEE;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      prev_hold = 1'b0;
    end else begin
      if (MemWrite) wr_q.push_back({DataAdr, WriteData});
      if (in_valid && in_ready) begin
        acc_cnt++;
        if (in_q.size() > 0) void'(in_q.pop_front());
      end
      if (out_valid && out_ready) out_q.push_back(out_data);
      if (start) start_cnt++;
      if (in_ready && (MemWrite || start)) viol++;
      if (prev_hold && (!out_valid || out_data !== prev_data)) viol++;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ":in_ready"},    32'(in_ready),    32'd1);
    check({tag, ":out_valid"},   32'(out_valid),   32'd0);
    check({tag, ":start"},       32'(start),       32'd0);
    check({tag, ":host_sel"},    32'(host_sel),    32'd1);
    check({tag, ":MemWrite"},    32'(MemWrite),    32'd0);
    check({tag, ":DataAdr"},     DataAdr,          32'd0);
    check({tag, ":WriteData"},   WriteData,        32'd0);
    check({tag, ":out_data"},    32'(out_data),    32'd0);
    check({tag, ":busy"},        32'(busy),        32'd0);
    check({tag, ":timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(tag, 32'(busy), 32'(lvl));
  endtask

  function automatic job_t mk_job(input logic [31:0] w0, input logic [31:0] w1,
                                  input logic [31:0] w2, input logic [31:0] w3,
                                  input logic [31:0] r0, input logic [31:0] r1,
                                  input int delay, input int rmode);
    job_t j;
    j.in_w[0]  = w0;
    j.in_w[1]  = w1;
    j.in_w[2]  = w2;
    j.in_w[3]  = w3;
    j.res_w[0] = r0;
    j.res_w[1] = r1;
    j.delay    = delay;
    j.rmode    = rmode;
    // A job that never sees EndFlag, or sees it too late, runs TIMEOUT cycles.
    j.exp_to    = (delay == 0) || (delay > int'(TIMEOUT));
    j.exp_start = j.exp_to ? int'(TIMEOUT) : delay;
    return j;
  endfunction

  // Job-level reference: each input word lands at its address, and each
  // result word comes back as four bytes, least significant first.
  function automatic void model_job(input job_t j, input bit timed_out);
    exp_wr.delete();
    exp_bytes.delete();
    for (int i = 0; i < int'(IN_WORDS); i++)
      exp_wr.push_back({32'(IN_BASE + 4 * i), j.in_w[i]});
    if (!timed_out)
      for (int w = 0; w < int'(OUT_WORDS); w++)
        for (int b = 0; b < 4; b++)
          exp_bytes.push_back(8'(j.res_w[w] >> (8 * b)));
  endfunction

  task automatic start_job(input job_t j, input bit junk);
    res_w      = j.res_w;
    end_delay  = j.delay;
    ready_mode = j.rmode;
    hold_junk  = junk;
    wr_q.delete();
    out_q.delete();
    acc_cnt   = 0;
    start_cnt = 0;
    viol      = 0;
    for (int i = 0; i < int'(IN_WORDS); i++)
      for (int b = 0; b < 4; b++)
        in_q.push_back(j.in_w[i][8 * b +: 8]);
  endtask

  task automatic run_job(input job_t j, input string tag);
    model_job(j, j.exp_to);
    start_job(j, 1'b1);
    wait_busy(1'b1, 20, {tag, ":busy_rise"});
    wait_busy(1'b0, 2000, {tag, ":busy_fall"});
    hold_junk = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check({tag, ":n_writes"}, 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
      check($sformatf("%s:wr%0d_adr", tag, i),  wr_q[i][63:32], exp_wr[i][63:32]);
      check($sformatf("%s:wr%0d_data", tag, i), wr_q[i][31:0],  exp_wr[i][31:0]);
    end
    check({tag, ":start_cycles"}, 32'(start_cnt), 32'(j.exp_start));
    check({tag, ":timeout_err"},  32'(timeout_err), 32'(j.exp_to));
    check({tag, ":n_bytes"}, 32'(out_q.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < out_q.size(); i++)
      check($sformatf("%s:byte%0d", tag, i), 32'(out_q[i]), 32'(exp_bytes[i]));
    check({tag, ":bytes_consumed"}, 32'(acc_cnt), 32'(4 * IN_WORDS));
    check({tag, ":handshake_rules"}, 32'(viol), 32'd0);
  endtask

  initial begin
    job_t tab[5];
    job_t j;
    int   n;

    reset      = 1'b0;
    res_w      = '0;
    end_delay  = 0;
    ready_mode = 0;
    hold_junk  = 1'b0;
    acc_cnt    = 0;
    start_cnt  = 0;
    viol       = 0;
    prev_hold  = 1'b0;
    prev_data  = 8'd0;

    tab[0] = mk_job(32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D,
                    32'hDEADBEEF, 32'h00000001, 50, 1);
    tab[1] = mk_job($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1, 0);
    tab[2] = mk_job($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 100, 2);
    tab[3] = mk_job($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 99, 1);
    tab[4] = mk_job($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 0, 0);

    repeat (2) @(negedge clk);
    #2;
    check_reset_values("in_reset");
    reset = 1'b1;
    @(negedge clk);
    #2;
    check_reset_values("idle_after_reset");

    for (int t = 0; t < 5; t++) run_job(tab[t], $sformatf("tab%0d", t));

    // timeout_err is sticky while idle and only reset clears it.
    repeat (20) @(negedge clk);
    #2;
    check("sticky:timeout_err", 32'(timeout_err), 32'd1);
    check("sticky:out_valid",   32'(out_valid),   32'd0);
    reset = 1'b0;
    @(negedge clk);
    #2;
    check("cleared:timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    #2;

    for (int r = 0; r < 6; r++) begin
      j = mk_job($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 int'($urandom_range(1, TIMEOUT)), int'($urandom_range(0, 2)));
      run_job(j, $sformatf("rand%0d", r));
    end

    // Reset while the third result byte is on the output.
    j = mk_job(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
               32'hDEADBEEF, 32'h00000001, 10, 0);
    start_job(j, 1'b0);
    n = 0;
    while (out_q.size() < 2 && n < 500) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("midsend:reached_byte2", 32'(out_q.size()), 32'd2);
    @(posedge clk);
    #2;
    check("midsend:byte2_before_reset", 32'(out_data), 32'hAD);
    reset = 1'b0;
    #1;
    check_reset_values("midsend_reset");
    @(negedge clk);
    in_q.delete();
    reset = 1'b1;
    @(negedge clk);
    #2;

    j = mk_job($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 30, 1);
    run_job(j, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
